// File: rtl/risc_pkg.sv
// Shared widths and sequencer state encoding for the IITB RISC datapath blocks.
package risc_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/lowest_set_bit_8.sv
// Priority encoder: index of the lowest set bit of an 8-bit list, plus a non-empty flag.
module lowest_set_bit_8
    import risc_pkg::*;
(
    input  logic [7:0]                list,
    output logic [REG_ADDR_WIDTH-1:0] idx,
    output logic                      any_set
);

    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (list[i]) idx = REG_ADDR_WIDTH'(i);
        end
    end

    assign any_set = |list;

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a register list R0..R7, one memory word transfer per selected register.
//   state   | meaning
//   IDLE    | waiting for Start; latches op, list and base address
//   XFER    | one request per selected register, advances on Mem_Ready
//   DONE    | one-cycle completion pulse, then back to IDLE
module lm_sm_sequencer
    import risc_pkg::*;
#(
    parameter int DATA_WIDTH     = risc_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = risc_pkg::REG_ADDR_WIDTH
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Is_Load,
    input  logic [7:0]                Reg_List,
    input  logic [DATA_WIDTH-1:0]     Base_Addr,
    output logic                      Busy,
    output logic                      Done,
    output logic [3:0]                Transfer_Count,
    output logic [REG_ADDR_WIDTH-1:0] RF_Address,
    output logic                      RF_Write,
    output logic [DATA_WIDTH-1:0]     RF_Data_C,
    input  logic [DATA_WIDTH-1:0]     RF_Data_In,
    output logic [DATA_WIDTH-1:0]     Mem_Address,
    output logic                      Mem_Read,
    output logic                      Mem_Write,
    output logic [DATA_WIDTH-1:0]     Mem_Data_Out,
    input  logic [DATA_WIDTH-1:0]     Mem_Data_In,
    input  logic                      Mem_Ready
);

    logic [1:0]                state;
    logic                      is_load_q;
    logic [7:0]                list_q;
    logic [DATA_WIDTH-1:0]     base_q;
    logic [3:0]                count_q;
    logic [7:0]                lsb_in;
    logic [7:0]                list_rest;
    logic [REG_ADDR_WIDTH-1:0] cur_idx;
    logic                      any_set;
    logic                      in_xfer;

    // One encoder serves both the empty-list check in IDLE and the current register in XFER.
    assign lsb_in = (state == ST_IDLE) ? Reg_List : list_q;

    lowest_set_bit_8 u_lsb (
        .list    (lsb_in),
        .idx     (cur_idx),
        .any_set (any_set)
    );

    assign list_rest = list_q & (list_q - 8'd1);
    assign in_xfer   = (state == ST_XFER);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            is_load_q <= 1'b0;
            list_q    <= '0;
            base_q    <= '0;
            count_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        is_load_q <= Is_Load;
                        list_q    <= Reg_List;
                        base_q    <= Base_Addr;
                        count_q   <= '0;
                        state     <= any_set ? ST_XFER : ST_DONE;
                    end
                end
                ST_XFER: begin
                    if (Mem_Ready) begin
                        list_q  <= list_rest;
                        count_q <= count_q + 4'd1;
                        if (list_rest == '0) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy           = (state != ST_IDLE);
    assign Done           = (state == ST_DONE);
    assign Transfer_Count = count_q;
    assign RF_Address     = in_xfer ? cur_idx : '0;
    assign Mem_Address    = in_xfer ? (base_q + DATA_WIDTH'(count_q)) : '0;
    assign Mem_Read       = in_xfer & is_load_q;
    assign Mem_Write      = in_xfer & ~is_load_q;
    assign RF_Write       = Mem_Read & Mem_Ready;
    assign RF_Data_C      = RF_Write ? Mem_Data_In : '0;
    assign Mem_Data_Out   = Mem_Write ? RF_Data_In : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed and randomized LM/SM runs checked against a transfer-list model of the sequencer.
module tb_lm_sm_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Is_Load;
    logic [7:0]  Reg_List;
    logic [15:0] Base_Addr;
    logic        Busy;
    logic        Done;
    logic [3:0]  Transfer_Count;
    logic [2:0]  RF_Address;
    logic        RF_Write;
    logic [15:0] RF_Data_C;
    logic [15:0] RF_Data_In;
    logic [15:0] Mem_Address;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [15:0] Mem_Data_Out;
    logic [15:0] Mem_Data_In;
    logic        Mem_Ready;

    logic [15:0] rf      [0:7];
    logic [15:0] mem     [0:65535];
    logic [15:0] exp_rf  [0:7];
    logic [15:0] exp_mem [0:65535];

    int checks   = 0;
    int failures = 0;
    int op_num   = 0;

    always #5 Clock = ~Clock;

    assign RF_Data_In  = rf[RF_Address];
    assign Mem_Data_In = mem[Mem_Address];

    lm_sm_sequencer dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Start          (Start),
        .Is_Load        (Is_Load),
        .Reg_List       (Reg_List),
        .Base_Addr      (Base_Addr),
        .Busy           (Busy),
        .Done           (Done),
        .Transfer_Count (Transfer_Count),
        .RF_Address     (RF_Address),
        .RF_Write       (RF_Write),
        .RF_Data_C      (RF_Data_C),
        .RF_Data_In     (RF_Data_In),
        .Mem_Address    (Mem_Address),
        .Mem_Read       (Mem_Read),
        .Mem_Write      (Mem_Write),
        .Mem_Data_Out   (Mem_Data_Out),
        .Mem_Data_In    (Mem_Data_In),
        .Mem_Ready      (Mem_Ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s op=%0d observed=%h expected=%h", tag, op_num, obs, expv);
        end
    endtask

    // Everything except Busy/Done/Transfer_Count must be zero outside XFER.
    task automatic chk_quiet(input string tag, input logic [3:0] cnt, input logic busy, input logic done);
        chk({tag, "_busy"},      Busy,           busy);
        chk({tag, "_done"},      Done,           done);
        chk({tag, "_count"},     Transfer_Count, cnt);
        chk({tag, "_rf_addr"},   RF_Address,     0);
        chk({tag, "_rf_write"},  RF_Write,       0);
        chk({tag, "_rf_data_c"}, RF_Data_C,      0);
        chk({tag, "_mem_addr"},  Mem_Address,    0);
        chk({tag, "_mem_read"},  Mem_Read,       0);
        chk({tag, "_mem_write"}, Mem_Write,      0);
        chk({tag, "_mem_dout"},  Mem_Data_Out,   0);
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endtask

    task automatic set_rf(input int r, input logic [15:0] v);
        rf[r]     = v;
        exp_rf[r] = v;
    endtask

    task automatic chk_rf_all(input string tag);
        for (int r = 0; r < 8; r++) chk($sformatf("%s_r%0d", tag, r), rf[r], exp_rf[r]);
    endtask

    // Entered #1 after a rising edge with the DUT idle; leaves it the same way.
    // stall < 0 picks 0..2 wait cycles per request at random; abort_after >= 0 pulls
    // Reset low during that transfer's request cycle.
    task automatic run_op(input logic ld, input logic [7:0] list, input logic [15:0] base,
                          input int stall, input int abort_after, input logic start_in_done);
        int          regs[$];
        int          k;
        int          nst;
        logic        rdy;
        logic [15:0] addr;
        logic        pend_rf, pend_mem;
        logic [2:0]  pend_rf_a;
        logic [15:0] pend_rf_d, pend_mem_a, pend_mem_d;

        op_num++;
        for (int i = 0; i < 8; i++) if (list[i]) regs.push_back(i);
        k = regs.size();

        Is_Load   = ld;
        Reg_List  = list;
        Base_Addr = base;
        Start     = 1'b1;
        Mem_Ready = 1'($urandom);
        @(posedge Clock);
        #1;
        Start     = 1'b0;
        Is_Load   = ~ld;
        Reg_List  = 8'($urandom);
        Base_Addr = 16'($urandom);

        for (int j = 0; j < k; j++) begin
            nst  = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            addr = base + 16'(j);
            for (int s = 0; s <= nst; s++) begin
                rdy       = (s == nst);
                Mem_Ready = rdy;
                Start     = 1'($urandom);
                @(negedge Clock);
                if (j == abort_after) begin
                    Reset = 1'b0;
                    #1;
                    chk_quiet("reset_mid", 4'd0, 1'b0, 1'b0);
                    @(posedge Clock);
                    #1;
                    Reset = 1'b1;
                    Start = 1'b0;
                    return;
                end
                chk("xfer_busy",     Busy,           1);
                chk("xfer_done",     Done,           0);
                chk("xfer_count",    Transfer_Count, j);
                chk("xfer_mem_addr", Mem_Address,    addr);
                chk("xfer_rf_addr",  RF_Address,     regs[j]);
                chk("xfer_mem_read", Mem_Read,       ld);
                chk("xfer_mem_wr",   Mem_Write,      !ld);
                chk("xfer_rf_write", RF_Write,       ld && rdy);
                if (ld && rdy) chk("xfer_rf_data_c", RF_Data_C, exp_mem[addr]);
                if (!ld)       chk("xfer_mem_dout",  Mem_Data_Out, exp_rf[regs[j]]);
                pend_rf    = RF_Write;
                pend_rf_a  = RF_Address;
                pend_rf_d  = RF_Data_C;
                pend_mem   = Mem_Write && Mem_Ready;
                pend_mem_a = Mem_Address;
                pend_mem_d = Mem_Data_Out;
                @(posedge Clock);
                if (pend_rf)  rf[pend_rf_a]   = pend_rf_d;
                if (pend_mem) mem[pend_mem_a] = pend_mem_d;
                #1;
            end
            if (ld) exp_rf[regs[j]] = exp_mem[addr];
            else    exp_mem[addr]   = exp_rf[regs[j]];
        end

        Start = start_in_done;
        if (start_in_done) Reg_List = 8'h0F;
        Mem_Ready = 1'($urandom);
        @(negedge Clock);
        chk_quiet("done_cycle", 4'(k), 1'b1, 1'b1);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(negedge Clock);
        chk_quiet("idle_after", 4'(k), 1'b0, 1'b0);
        @(posedge Clock);
        #1;

        chk_rf_all("rf_final");
        for (int j = 0; j < k; j++)
            chk($sformatf("mem_final_%0d", j), mem[base + 16'(j)], exp_mem[base + 16'(j)]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b0;
        Start     = 1'b0;
        Is_Load   = 1'b0;
        Reg_List  = 8'h00;
        Base_Addr = 16'h0000;
        Mem_Ready = 1'b0;
        for (int a = 0; a < 65536; a++) set_mem(16'(a), 16'($urandom));
        for (int r = 0; r < 8; r++) set_rf(r, 16'($urandom));

        #12;
        chk_quiet("reset", 4'd0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        chk_quiet("post_reset", 4'd0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;

        set_mem(16'h0010, 16'hAAAA);
        set_mem(16'h0011, 16'hBBBB);
        run_op(1'b1, 8'h05, 16'h0010, 0, -1, 1'b0);
        chk("t1_r0", rf[0], 16'hAAAA);
        chk("t1_r2", rf[2], 16'hBBBB);

        set_rf(0, 16'h1234);
        set_rf(7, 16'hBEEF);
        run_op(1'b0, 8'h81, 16'h0100, 0, -1, 1'b0);
        chk("t2_m100", mem[16'h0100], 16'h1234);
        chk("t2_m101", mem[16'h0101], 16'hBEEF);

        run_op(1'b1, 8'hFF, 16'($urandom), 2, -1, 1'b0);

        run_op(1'($urandom), 8'h00, 16'h1234, 0, -1, 1'b1);

        run_op(1'b0, 8'h03, 16'hFFFF, -1, -1, 1'b0);

        set_rf(6, 16'h6666);
        set_rf(7, 16'h7777);
        run_op(1'b1, 8'hF0, 16'h0200, 0, 2, 1'b0);
        chk_rf_all("abort_rf");
        chk("abort_r6", rf[6], 16'h6666);
        chk("abort_r7", rf[7], 16'h7777);
        @(negedge Clock);
        chk_quiet("after_abort", 4'd0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        run_op(1'b0, 8'h0C, 16'h0300, -1, -1, 1'b0);

        repeat (25) begin
            run_op(1'($urandom), 8'($urandom), 16'($urandom), -1, -1, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
